instruction_fetch_queue: RTL and testbench

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/instruction_fetch_queue_if.sv | 27 ++
 rtl/instruction_fetch_queue.sv | 126 ++++++++++++
 tb/tb_instruction_fetch_queue.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-queue bus: memory request/response, dispatch pop and redirect.
// The queue itself connects through the master modport. The memory/dispatch
// environment connects through the slave modport.
interface instruction_fetch_queue_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fetch_req;
  logic [DATA_WIDTH-1:0] fetch_addr;
  logic                  fetch_ack;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  Read_enable;
  logic                  empty;
  logic [DATA_WIDTH-1:0] Instruction;
  logic [DATA_WIDTH-1:0] PC_out;
  logic                  jump_branch_valid;
  logic [DATA_WIDTH-1:0] jump_branch_address;

  modport master (
    output fetch_req, fetch_addr, empty, Instruction, PC_out,
    input  fetch_ack, fetch_data, Read_enable, jump_branch_valid, jump_branch_address
  );

  modport slave (
    input  fetch_req, fetch_addr, empty, Instruction, PC_out,
    output fetch_ack, fetch_data, Read_enable, jump_branch_valid, jump_branch_address
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue. It keeps at most one memory request in flight.
// Each response is buffered with its PC in a small circular queue.
// The queue head is presented show-ahead to dispatch.
// A jump/branch redirect flushes the queue and reloads the PC.
// A response that is still in flight when a redirect arrives is discarded.
module instruction_fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input logic                       clk,
  input logic                       reset,
  instruction_fetch_queue_if.master bus
);

  localparam int             PW      = $clog2(DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] req_pc_reg;
  logic [CW-1:0]         count_reg;
  logic [PW-1:0]         head_reg;
  logic [PW-1:0]         tail_reg;

  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic redirect;
  logic empty_w;

  assign redirect = bus.jump_branch_valid;
  assign empty_w  = (count_reg == '0);
  // Dispatch pops are meaningless while a redirect flushes the queue.
  assign pop      = bus.Read_enable && !empty_w && !redirect;

  // Next-state logic and the issue/push strobes. A redirect always wins over fetch activity.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    push       = 1'b0;
    case (state_reg)
      FETCH: begin
        // The room check happens here, so a later push never finds the queue full.
        if (!redirect && (count_reg < DEPTH_C)) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_next = bus.fetch_ack ? FETCH : DROP;
        end else if (bus.fetch_ack) begin
          push       = 1'b1;
          state_next = FETCH;
        end
      end
      DROP: begin
        if (bus.fetch_ack) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  assign bus.fetch_req   = issue && !reset;
  assign bus.fetch_addr  = pc_reg;
  assign bus.empty       = empty_w;
  assign bus.Instruction = empty_w ? '0 : instr_mem[head_reg];
  assign bus.PC_out      = empty_w ? '0 : pc_mem[head_reg];

  // Control state. This covers the FSM, the PC and the queue pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= FETCH;
      pc_reg     <= RESET_PC;
      req_pc_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      tail_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (redirect) begin
        pc_reg <= bus.jump_branch_address & ~DATA_WIDTH'(3);
      end else if (issue) begin
        pc_reg <= pc_reg + DATA_WIDTH'(4);
      end
      if (issue) begin
        req_pc_reg <= pc_reg;
      end
      if (redirect) begin
        count_reg <= '0;
        head_reg  <= '0;
        tail_reg  <= '0;
      end else begin
        if (push) tail_reg <= tail_reg + PW'(1);
        if (pop)  head_reg <= head_reg + PW'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Queue storage is written at the tail on push. It needs no reset because empty masks the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_reg] <= bus.fetch_data;
      pc_mem[tail_reg]    <= req_pc_reg;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue.
// It runs directed redirect/reset scenarios followed by randomized traffic.
// Every cycle is compared against a transaction-level model.
// The model keeps a queue of {pc, instr}, a PC, an "in flight" flag and a "discard" flag.
module tb_instruction_fetch_queue;

  localparam int          DW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic clk;
  logic reset;

  instruction_fetch_queue_if #(.DATA_WIDTH(DW)) bus ();

  instruction_fetch_queue #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;

  entry_t      q[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_busy;
  bit          m_drop;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc     = RESET_PC;
    m_req_pc = '0;
    m_busy   = 0;
    m_drop   = 0;
  endtask

  // Apply inputs on the falling edge, then compare outputs against the model.
  task automatic drive(input logic a, input logic [31:0] d, input logic re,
                       input logic jv, input logic [31:0] ja);
    logic exp_req;
    @(negedge clk);
    bus.fetch_ack           = a;
    bus.fetch_data          = d;
    bus.Read_enable         = re;
    bus.jump_branch_valid   = jv;
    bus.jump_branch_address = ja;
    #1;
    exp_req = !m_busy && (q.size() < DEPTH) && !jv;
    check_val("fetch_req",   {31'b0, bus.fetch_req}, {31'b0, exp_req});
    check_val("fetch_addr",  bus.fetch_addr, m_pc);
    check_val("empty",       {31'b0, bus.empty}, {31'b0, q.size() == 0});
    check_val("Instruction", bus.Instruction, (q.size() == 0) ? 32'h0 : q[0].instr);
    check_val("PC_out",      bus.PC_out,      (q.size() == 0) ? 32'h0 : q[0].pc);
  endtask

  // Let the rising edge happen, then advance the model with the inputs that were applied.
  task automatic advance();
    bit a, re, jv, do_pop, can_issue;
    logic [31:0] d, ja;
    @(posedge clk);
    a  = bus.fetch_ack;
    d  = bus.fetch_data;
    re = bus.Read_enable;
    jv = bus.jump_branch_valid;
    ja = bus.jump_branch_address;
    can_issue = !m_busy && (q.size() < DEPTH);
    if (jv) begin
      q.delete();
      m_pc = ja & 32'hFFFF_FFFC;
      if (m_busy) begin
        if (a) begin
          m_busy = 0;
          m_drop = 0;
        end else begin
          m_drop = 1;
        end
      end
      $display("redirect to 0x%08h", m_pc);
    end else begin
      do_pop = re && (q.size() != 0);
      if (m_busy && a) begin
        if (!m_drop) begin
          q.push_back('{pc: m_req_pc, instr: d});
          $display("enqueue pc=0x%08h instr=0x%08h", m_req_pc, d);
        end else begin
          $display("discard instr=0x%08h", d);
        end
        m_busy = 0;
        m_drop = 0;
      end else if (can_issue) begin
        m_busy   = 1;
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
      if (do_pop) begin
        $display("pop pc=0x%08h", q[0].pc);
        void'(q.pop_front());
      end
    end
  endtask

  // Assert reset between clock edges and check that outputs respond at once.
  // The bench holds reset across two edges with ack/pop active, since both must be ignored.
  // It releases reset just after an edge so the bench stays aligned with the model.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_empty",       {31'b0, bus.empty},     32'h1);
    check_val("rst_fetch_req",   {31'b0, bus.fetch_req}, 32'h0);
    check_val("rst_Instruction", bus.Instruction,        32'h0);
    check_val("rst_PC_out",      bus.PC_out,             32'h0);
    check_val("rst_fetch_addr",  bus.fetch_addr,         RESET_PC);
    model_reset();
    bus.fetch_ack         = 1'b1;
    bus.Read_enable       = 1'b1;
    bus.jump_branch_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    $display("reset released");
  endtask

  initial begin
    bus.fetch_ack           = 1'b0;
    bus.fetch_data          = '0;
    bus.Read_enable         = 1'b0;
    bus.jump_branch_valid   = 1'b0;
    bus.jump_branch_address = '0;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    apply_reset();

    // Fill: ack every request one cycle later and never pop.
    for (int i = 0; i < 10; i++) begin
      drive(m_busy, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
      advance();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_val("full_no_req",   {31'b0, bus.fetch_req}, 32'h0);
    check_val("full_head_pc",  bus.PC_out,             32'h0);
    check_val("full_instr",    bus.Instruction,        32'h0000_0013);
    check_val("full_next_pc",  bus.fetch_addr,         32'h10);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_val("pop_head_pc",   bus.PC_out,             32'h4);
    check_val("pop_req",       {31'b0, bus.fetch_req}, 32'h1);
    check_val("pop_req_addr",  bus.fetch_addr,         32'h10);
    advance();
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    advance();

    // Redirect in FETCH with two entries queued.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(m_busy, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
      advance();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h103);
    check_val("rdf_no_req",    {31'b0, bus.fetch_req}, 32'h0);
    check_val("rdf_not_empty", {31'b0, bus.empty},     32'h0);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_val("rdf_empty",     {31'b0, bus.empty},     32'h1);
    check_val("rdf_addr",      bus.fetch_addr,         32'h100);
    check_val("rdf_req",       {31'b0, bus.fetch_req}, 32'h1);
    advance();

    // Redirect in WAIT. The late response must be dropped.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    advance();
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    check_val("drop_no_req",   {31'b0, bus.fetch_req}, 32'h0);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_val("drop_empty",    {31'b0, bus.empty},     32'h1);
    check_val("drop_addr",     bus.fetch_addr,         32'h200);
    advance();
    drive(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_val("enq_pc",        bus.PC_out,             32'h200);
    check_val("enq_instr",     bus.Instruction,        32'h0000_1234);
    advance();

    // Redirect coinciding with fetch_ack and Read_enable.
    drive(1'b1, 32'h0000_5555, 1'b1, 1'b1, 32'h40);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_val("rdw_empty",     {31'b0, bus.empty},     32'h1);
    check_val("rdw_addr",      bus.fetch_addr,         32'h40);
    check_val("rdw_req",       {31'b0, bus.fetch_req}, 32'h1);
    advance();

    // Pop while empty, then reset in the middle of WAIT.
    apply_reset();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_val("underflow_empty", {31'b0, bus.empty},   32'h1);
    advance();
    apply_reset();
    drive(1'b1, 32'h0000_0077, 1'b0, 1'b0, 32'h0);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_val("stale_ack_empty", {31'b0, bus.empty},   32'h1);
    advance();

    // Randomized traffic. Acks also arrive when no request is in flight.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 99) < 5), $urandom);
      advance();
      if ($urandom_range(0, 399) == 0) apply_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
